// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; one quotient bit per clock.
// Result is packed {remainder, quotient}; outputs are registered and zero unless ready_o.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;      // remaining dividend bits, quotient bits shift in from the bottom
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] rem;
   logic             sign1, sign2, sgn_mode;

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_nxt, quo_nxt, rem_fix, quo_fix;
   logic [WIDTH-1:0] abs1, abs2;
   logic             last_step, accept, div_zero;

   always_comb begin
      abs1      = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
      abs2      = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
      accept    = start_i && !annul_i;
      div_zero  = (opdata2_i == '0);
      // bit WIDTH of the trial difference acts as the borrow: set means divisor did not fit
      trial     = {rem, dvd[WIDTH-1]} - {1'b0, dsr};
      rem_nxt   = trial[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
      quo_nxt   = {dvd[WIDTH-2:0], ~trial[WIDTH]};
      quo_fix   = (sgn_mode && (sign1 ^ sign2)) ? -quo_nxt : quo_nxt;
      rem_fix   = (sgn_mode && sign1) ? -rem_nxt : rem_nxt;
      last_step = (cnt == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FREE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FREE:    if (accept) state_nxt = div_zero ? BYZERO : ON;
         BYZERO:  state_nxt = annul_i ? FREE : END;
         ON: begin
            if (annul_i)        state_nxt = FREE;
            else if (last_step) state_nxt = END;
         end
         END:     if (annul_i || !start_i) state_nxt = FREE;
         default: state_nxt = FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         rem      <= '0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         sgn_mode <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               result_o <= '0;
               ready_o  <= 1'b0;
               if (accept && !div_zero) begin
                  dvd      <= abs1;
                  dsr      <= abs2;
                  rem      <= '0;
                  cnt      <= '0;
                  sign1    <= signed_div_i & opdata1_i[WIDTH-1];
                  sign2    <= signed_div_i & opdata2_i[WIDTH-1];
                  sgn_mode <= signed_div_i;
               end
            end
            BYZERO: begin
               result_o <= '0;
               ready_o  <= !annul_i;
            end
            ON: begin
               if (annul_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end else begin
                  rem <= rem_nxt;
                  dvd <= quo_nxt;
                  cnt <= cnt + 1'b1;
                  if (last_step) begin
                     result_o <= {rem_fix, quo_fix};
                     ready_o  <= 1'b1;
                  end
               end
            end
            END: begin
               if (annul_i || !start_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
               end
            end
            default: begin
               result_o <= '0;
               ready_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule
